// File: rtl/bridge_bus_arbiter.sv
// Two-requester round-robin arbiter in front of the Bridge CPU-side port.
// Requester 0 is the CPU load/store unit, requester 1 the loader/DMA engine.
// Ownership is held for at most MAX_BURST accepted transfers while the other
// side waits; read data is returned with a tagged, fixed-latency valid.
//
// Handshake (req/gnt, valid/ready style): a transfer is accepted in exactly
// those cycles where mx_req and mx_gnt are both high. A requester raises
// mx_req with mx_addr/mx_wen/mx_wdata and holds all of them stable until it
// sees mx_gnt high; mx_gnt never rises without mx_req. Reads return on
// mx_rvalid exactly READ_LATENCY cycles after acceptance, for one cycle.
module bridge_bus_arbiter #(
  parameter int MAX_BURST    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk_from_cpu,
  input  logic        rst_from_cpu,
  input  logic        m0_req,
  input  logic [15:0] m0_addr,
  input  logic        m0_wen,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic        m1_req,
  input  logic [15:0] m1_addr,
  input  logic        m1_wen,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic [15:0] addr_to_bridge,
  output logic        wen_to_bridge,
  output logic [31:0] wdata_to_bridge,
  input  logic [31:0] rdata_from_bridge,
  output logic [1:0]  owner
);

  // Encoding matches the owner debug output: 0 none, 1 m0, 2 m1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_rr;      // requester favoured on the next tie
  logic [7:0]              r_beat;    // accepted transfers in this tenure
  logic [READ_LATENCY-1:0] r_rd_vld;
  logic [READ_LATENCY-1:0] r_rd_id;

  logic w_gnt0;
  logic w_gnt1;
  logic w_last;
  logic w_rd_accept;

  assign w_gnt0 = (r_state == OWN0) && m0_req;
  assign w_gnt1 = (r_state == OWN1) && m1_req;
  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  // Compare in 9 bits so MAX_BURST = 255 cannot wrap the beat counter test.
  assign w_last = (({1'b0, r_beat} + 9'd1) == 9'(MAX_BURST));

  // Shared bus carries the granted requester's fields, zero when idle.
  always_comb begin
    addr_to_bridge  = '0;
    wen_to_bridge   = 1'b0;
    wdata_to_bridge = '0;
    if (w_gnt0) begin
      addr_to_bridge  = m0_addr;
      wen_to_bridge   = m0_wen;
      wdata_to_bridge = m0_wdata;
    end else if (w_gnt1) begin
      addr_to_bridge  = m1_addr;
      wen_to_bridge   = m1_wen;
      wdata_to_bridge = m1_wdata;
    end
  end

  assign w_rd_accept = (w_gnt0 | w_gnt1) & ~wen_to_bridge;

  // Ownership FSM: arbitration from IDLE, early release, burst-limit handover.
  always_ff @(posedge clk_from_cpu) begin
    if (!rst_from_cpu) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_beat <= '0;
          if (m0_req && (!m1_req || !r_rr)) begin
            r_state <= OWN0;
            r_rr    <= 1'b1;
          end else if (m1_req) begin
            r_state <= OWN1;
            r_rr    <= 1'b0;
          end
        end
        OWN0: begin
          if (!m0_req) begin
            r_beat <= '0;
            if (m1_req) begin
              r_state <= OWN1;
              r_rr    <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_last) begin
            // Limit reached: hand over if m1 waits, otherwise start a new tenure.
            r_beat <= '0;
            if (m1_req) begin
              r_state <= OWN1;
              r_rr    <= 1'b0;
            end
          end else begin
            r_beat <= r_beat + 8'd1;
          end
        end
        OWN1: begin
          if (!m1_req) begin
            r_beat <= '0;
            if (m0_req) begin
              r_state <= OWN0;
              r_rr    <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_last) begin
            r_beat <= '0;
            if (m0_req) begin
              r_state <= OWN0;
              r_rr    <= 1'b1;
            end
          end else begin
            r_beat <= r_beat + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_beat  <= '0;
        end
      endcase
    end
  end

  // Read return pipeline: {valid, id} travels READ_LATENCY stages.
  always_ff @(posedge clk_from_cpu) begin
    if (!rst_from_cpu) begin
      r_rd_vld <= '0;
      r_rd_id  <= '0;
    end else begin
      r_rd_vld[0] <= w_rd_accept;
      r_rd_id[0]  <= w_gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_rd_vld[i] <= r_rd_vld[i-1];
        r_rd_id[i]  <= r_rd_id[i-1];
      end
    end
  end

  assign m0_rvalid = r_rd_vld[READ_LATENCY-1] & ~r_rd_id[READ_LATENCY-1];
  assign m1_rvalid = r_rd_vld[READ_LATENCY-1] &  r_rd_id[READ_LATENCY-1];
  assign m0_rdata  = rdata_from_bridge;
  assign m1_rdata  = rdata_from_bridge;
  assign owner     = r_state;

endmodule

// File: tb/tb_bridge_bus_arbiter.sv
// Testbench for bridge_bus_arbiter. Two instances share one stimulus stream:
// instance 0 with MAX_BURST=8/READ_LATENCY=1, instance 1 with MAX_BURST=1/
// READ_LATENCY=3. A behavioural model predicts both every cycle.
module tb_bridge_bus_arbiter;

  typedef struct packed {
    logic        rst;
    logic        r0;
    logic        w0;
    logic [15:0] a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [15:0] a1;
    logic [31:0] d1;
    logic [31:0] rdin;
  } stim_t;

  typedef struct packed {
    stim_t       s;
    logic        e_g1;
    logic [15:0] e_addr;
    logic        e_wen;
    logic        e_rv1;
    logic [31:0] e_rd1;
    logic [1:0]  e_own;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        rst;
  logic        r0, w0, r1, w1;
  logic [15:0] a0, a1;
  logic [31:0] d0, d1, rdin;

  logic [1:0]        o_g0, o_g1, o_rv0, o_rv1, o_wen;
  logic [1:0][31:0]  o_rd0, o_rd1, o_wd;
  logic [1:0][15:0]  o_addr;
  logic [1:0][1:0]   o_own;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bridge_bus_arbiter #(.MAX_BURST(8), .READ_LATENCY(1)) u_dut_a (
    .clk_from_cpu(clk), .rst_from_cpu(rst),
    .m0_req(r0), .m0_addr(a0), .m0_wen(w0), .m0_wdata(d0),
    .m0_gnt(o_g0[0]), .m0_rdata(o_rd0[0]), .m0_rvalid(o_rv0[0]),
    .m1_req(r1), .m1_addr(a1), .m1_wen(w1), .m1_wdata(d1),
    .m1_gnt(o_g1[0]), .m1_rdata(o_rd1[0]), .m1_rvalid(o_rv1[0]),
    .addr_to_bridge(o_addr[0]), .wen_to_bridge(o_wen[0]),
    .wdata_to_bridge(o_wd[0]), .rdata_from_bridge(rdin), .owner(o_own[0])
  );

  bridge_bus_arbiter #(.MAX_BURST(1), .READ_LATENCY(3)) u_dut_b (
    .clk_from_cpu(clk), .rst_from_cpu(rst),
    .m0_req(r0), .m0_addr(a0), .m0_wen(w0), .m0_wdata(d0),
    .m0_gnt(o_g0[1]), .m0_rdata(o_rd0[1]), .m0_rvalid(o_rv0[1]),
    .m1_req(r1), .m1_addr(a1), .m1_wen(w1), .m1_wdata(d1),
    .m1_gnt(o_g1[1]), .m1_rdata(o_rd1[1]), .m1_rvalid(o_rv1[1]),
    .addr_to_bridge(o_addr[1]), .wen_to_bridge(o_wen[1]),
    .wdata_to_bridge(o_wd[1]), .rdata_from_bridge(rdin), .owner(o_own[1])
  );

  // ---------------- scoreboard counters ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Owner: 0 none, 1 m0, 2 m1. Read returns are booked into a calendar
  // indexed by the cycle they are due, rather than shifted through stages.
  int m_mb  [2] = '{8, 1};
  int m_lat [2] = '{1, 3};
  int m_own [2];
  int m_fav [2];          // requester (1 or 2) that wins the next tie
  int m_beat[2];
  int m_cal [2][16];      // 0 nothing due, 1 m0 read due, 2 m1 read due
  int cyc = 0;
  bit m_init = 1'b0;
  bit exp_a_g0 = 1'b0;
  bit exp_a_g1 = 1'b0;

  function automatic bit granted(input int k, input int who);
    return (m_own[k] == who) && ((who == 1) ? (r0 == 1'b1) : (r1 == 1'b1));
  endfunction

  task automatic cmp_model();
    bit          eg0, eg1;
    logic [48:0] eb;
    int          due;
    exp_a_g0 = 1'b0;
    exp_a_g1 = 1'b0;
    if (!m_init) return;
    for (int k = 0; k < 2; k++) begin
      eg0 = granted(k, 1);
      eg1 = granted(k, 2);
      if (k == 0) begin
        exp_a_g0 = eg0;
        exp_a_g1 = eg1;
      end
      eb = '0;
      if (eg0) eb = {a0, w0, d0};
      else if (eg1) eb = {a1, w1, d1};
      due = m_cal[k][cyc % 16];
      chk($sformatf("i%0d_gnt c%0d", k, cyc), 64'({o_g1[k], o_g0[k]}), 64'({eg1, eg0}));
      chk($sformatf("i%0d_bus c%0d", k, cyc), 64'({o_addr[k], o_wen[k], o_wd[k]}), 64'(eb));
      chk($sformatf("i%0d_owner c%0d", k, cyc), 64'(o_own[k]), 64'(m_own[k]));
      chk($sformatf("i%0d_rvalid c%0d", k, cyc), 64'({o_rv1[k], o_rv0[k]}),
          64'({due == 2, due == 1}));
      if (due == 1) chk($sformatf("i%0d_m0_rdata c%0d", k, cyc), 64'(o_rd0[k]), 64'(rdin));
      if (due == 2) chk($sformatf("i%0d_m1_rdata c%0d", k, cyc), 64'(o_rd1[k]), 64'(rdin));
    end
  endtask

  task automatic take(input int k, input int who);
    m_own[k]  = who;
    m_fav[k]  = 3 - who;
    m_beat[k] = 0;
  endtask

  task automatic mdl_update();
    bit req[3];
    int me;
    int other;
    req[0] = 1'b0;
    req[1] = (r0 == 1'b1);
    req[2] = (r1 == 1'b1);
    if (rst == 1'b0) begin
      for (int k = 0; k < 2; k++) begin
        m_own[k] = 0; m_fav[k] = 1; m_beat[k] = 0;
        for (int j = 0; j < 16; j++) m_cal[k][j] = 0;
      end
      m_init = 1'b1;
    end else if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        m_cal[k][cyc % 16] = 0;
        if (granted(k, 1) && w0 == 1'b0) m_cal[k][(cyc + m_lat[k]) % 16] = 1;
        if (granted(k, 2) && w1 == 1'b0) m_cal[k][(cyc + m_lat[k]) % 16] = 2;
        if (m_own[k] == 0) begin
          if (req[1] && req[2]) take(k, m_fav[k]);
          else if (req[1]) take(k, 1);
          else if (req[2]) take(k, 2);
        end else begin
          me    = m_own[k];
          other = 3 - me;
          if (!req[me]) begin
            m_beat[k] = 0;
            if (req[other]) take(k, other);
            else m_own[k] = 0;
          end else begin
            m_beat[k]++;
            if (m_beat[k] == m_mb[k]) begin
              m_beat[k] = 0;
              if (req[other]) take(k, other);
            end
          end
        end
      end
    end
    cyc++;
  endtask

  // ---------------- driver ----------------
  function automatic stim_t idle_s();
    stim_t s;
    s      = '0;
    s.rst  = 1'b1;
    s.rdin = $urandom;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    @(negedge clk);
    rst = s.rst; r0 = s.r0; w0 = s.w0; a0 = s.a0; d0 = s.d0;
    r1 = s.r1; w1 = s.w1; a1 = s.a1; d1 = s.d1; rdin = s.rdin;
    #2;
    cmp_model();
    mdl_update();
  endtask

  function automatic logic [1:0] gp(input int k);
    return {o_g1[k], o_g0[k]};
  endfunction

  // ---------------- test sequence ----------------
  vec_t  vt[5];
  stim_t s;
  bit    p_r0, p_r1;
  logic  p_w0, p_w1;
  logic [15:0] p_a0, p_a1;
  logic [31:0] p_d0, p_d1;

  initial begin
    rst = 1'b0; r0 = 1'b0; r1 = 1'b0; w0 = 1'b0; w1 = 1'b0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0; rdin = '0;

    // Reset held 3 cycles with both requesting, then release.
    for (int i = 0; i < 3; i++) begin
      s = idle_s(); s.rst = 1'b0; s.r0 = 1'b1; s.r1 = 1'b1;
      drive(s);
      if (i > 0) begin
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("rst_gnt i%0d", k), 64'(gp(k)), 64'(2'b00));
          chk($sformatf("rst_wen i%0d", k), 64'(o_wen[k]), 64'(0));
          chk($sformatf("rst_owner i%0d", k), 64'(o_own[k]), 64'(0));
          chk($sformatf("rst_rvalid i%0d", k), 64'({o_rv1[k], o_rv0[k]}), 64'(0));
        end
      end
    end
    s = idle_s(); s.r0 = 1'b1; s.r1 = 1'b1;
    drive(s);
    chk("rel_owner_bubble", 64'(o_own[0]), 64'(0));
    s = idle_s();
    drive(s);
    chk("rel_owner_m0", 64'(o_own[0]), 64'(1));

    // Single requester m1: read 0xF000, write 0xFF to 0xF040 (instance 0).
    for (int i = 0; i < 5; i++) begin
      vt[i] = '0;
      vt[i].s.rst = 1'b1;
    end
    vt[0].s.r1 = 1'b1; vt[0].s.a1 = 16'hF000;
    vt[0].e_own = 2'd0;
    vt[1].s.r1 = 1'b1; vt[1].s.a1 = 16'hF000;
    vt[1].e_g1 = 1'b1; vt[1].e_addr = 16'hF000; vt[1].e_own = 2'd2;
    vt[2].s.r1 = 1'b1; vt[2].s.w1 = 1'b1; vt[2].s.a1 = 16'hF040;
    vt[2].s.d1 = 32'h0000_00FF; vt[2].s.rdin = 32'hCAFE_0001;
    vt[2].e_g1 = 1'b1; vt[2].e_addr = 16'hF040; vt[2].e_wen = 1'b1;
    vt[2].e_rv1 = 1'b1; vt[2].e_rd1 = 32'hCAFE_0001; vt[2].e_own = 2'd2;
    vt[3].e_own = 2'd2;
    vt[4].e_own = 2'd0;
    for (int i = 0; i < 5; i++) begin
      drive(vt[i].s);
      chk($sformatf("vec%0d_m1_gnt", i), 64'(o_g1[0]), 64'(vt[i].e_g1));
      chk($sformatf("vec%0d_addr", i), 64'(o_addr[0]), 64'(vt[i].e_addr));
      chk($sformatf("vec%0d_wen", i), 64'(o_wen[0]), 64'(vt[i].e_wen));
      chk($sformatf("vec%0d_m1_rvalid", i), 64'(o_rv1[0]), 64'(vt[i].e_rv1));
      chk($sformatf("vec%0d_owner", i), 64'(o_own[0]), 64'(vt[i].e_own));
      if (vt[i].e_rv1) chk($sformatf("vec%0d_m1_rdata", i), 64'(o_rd1[0]), 64'(vt[i].e_rd1));
    end

    // Contention: bursts of 8 on instance 0, strict alternation on instance 1.
    for (int i = 0; i < 49; i++) begin
      s = idle_s(); s.r0 = 1'b1; s.r1 = 1'b1; s.a0 = 16'h1000; s.a1 = 16'h2000;
      drive(s);
      if (i == 0) begin
        chk("cont_bubble_i0", 64'(gp(0)), 64'(2'b00));
        chk("cont_bubble_i1", 64'(gp(1)), 64'(2'b00));
      end else begin
        chk($sformatf("cont_i0 c%0d", i), 64'(gp(0)), 64'((((i - 1) / 8) % 2 == 0) ? 2'b01 : 2'b10));
        chk($sformatf("cont_i1 c%0d", i), 64'(gp(1)), 64'((((i - 1) % 2) == 0) ? 2'b01 : 2'b10));
      end
    end
    drive(idle_s());

    // Early release: m0 drops after 3 beats, m1 then gets a full fresh burst.
    s = idle_s(); s.r0 = 1'b1;
    drive(s);
    chk("early_bubble", 64'(o_own[0]), 64'(0));
    for (int i = 0; i < 3; i++) begin
      s = idle_s(); s.r0 = 1'b1; s.r1 = 1'b1; s.w0 = 1'b1;
      drive(s);
      chk($sformatf("early_m0 b%0d", i), 64'(gp(0)), 64'(2'b01));
    end
    s = idle_s(); s.r1 = 1'b1;
    drive(s);
    chk("early_drop_gnt", 64'(gp(0)), 64'(2'b00));
    for (int i = 0; i < 8; i++) begin
      s = idle_s(); s.r0 = 1'b1; s.r1 = 1'b1; s.w1 = 1'b1;
      drive(s);
      if (i == 0) chk("early_owner_m1", 64'(o_own[0]), 64'(2));
      chk($sformatf("early_m1 b%0d", i), 64'(gp(0)), 64'(2'b10));
    end
    s = idle_s(); s.r0 = 1'b1;
    drive(s);
    chk("early_back_m0", 64'(gp(0)), 64'(2'b01));
    drive(idle_s());

    // Read tagging across handover on instance 1 (latency 3, burst 1).
    s = idle_s(); s.rst = 1'b0;
    drive(s);
    for (int i = 0; i < 7; i++) begin
      s = idle_s();
      if (i <= 1) begin s.r0 = 1'b1; s.a0 = 16'h4000; end
      if (i == 1 || i == 2) begin s.r1 = 1'b1; s.a1 = 16'h5000; end
      drive(s);
      if (i == 1) chk("tag_m0_gnt", 64'(gp(1)), 64'(2'b01));
      if (i == 2) chk("tag_m1_gnt", 64'(gp(1)), 64'(2'b10));
      if (i >= 1) chk($sformatf("tag_rvalid c%0d", i), 64'({o_rv1[1], o_rv0[1]}),
                      64'((i == 4) ? 2'b01 : (i == 5) ? 2'b10 : 2'b00));
      if (i == 4) chk("tag_m0_rdata", 64'(o_rd0[1]), 64'(rdin));
      if (i == 5) chk("tag_m1_rdata", 64'(o_rd1[1]), 64'(rdin));
    end

    // Reset the cycle after an m0 read grant (instance 1): read is dropped.
    for (int i = 0; i < 7; i++) begin
      s = idle_s();
      if (i <= 1) begin s.r0 = 1'b1; s.a0 = 16'h4004; end
      if (i == 2) s.rst = 1'b0;
      drive(s);
      if (i == 1) chk("mid_rst_gnt", 64'(gp(1)), 64'(2'b01));
      if (i >= 2) chk($sformatf("mid_rst_rvalid c%0d", i), 64'({o_rv1[1], o_rv0[1]}), 64'(0));
      if (i == 3) chk("mid_rst_owner", 64'(o_own[1]), 64'(0));
    end

    // Randomized traffic; requests stay stable until instance 0 grants them.
    p_r0 = 1'b0; p_r1 = 1'b0;
    p_w0 = 1'b0; p_w1 = 1'b0; p_a0 = '0; p_a1 = '0; p_d0 = '0; p_d1 = '0;
    for (int c = 0; c < 800; c++) begin
      s = idle_s();
      if (!p_r0 && $urandom_range(3) != 0) begin
        p_r0 = 1'b1; p_w0 = 1'($urandom_range(1)); p_a0 = 16'($urandom); p_d0 = $urandom;
      end
      if (!p_r1 && $urandom_range(3) != 0) begin
        p_r1 = 1'b1; p_w1 = 1'($urandom_range(1)); p_a1 = 16'($urandom); p_d1 = $urandom;
      end
      s.r0 = p_r0; s.w0 = p_w0; s.a0 = p_a0; s.d0 = p_d0;
      s.r1 = p_r1; s.w1 = p_w1; s.a1 = p_a1; s.d1 = p_d1;
      if ($urandom_range(79) == 0) s.rst = 1'b0;
      drive(s);
      if (exp_a_g0 || !s.rst) p_r0 = 1'b0;
      if (exp_a_g1 || !s.rst) p_r1 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bridge_bus_arbiter.md
Name: bridge_bus_arbiter

Overview:
- Two-requester arbiter in front of the Bridge's single CPU-side port (16-bit byte address, write enable, 32-bit write data, 32-bit read data).
- Requester 0 is the CPU load/store unit; requester 1 is the program loader/DMA engine.
- Grants ownership round-robin with a bounded burst length and drives the shared bus from the current owner.
- Routes read data back to the issuing requester with a tagged, fixed-latency valid.

Parameters:
- MAX_BURST, 8, maximum accepted transfers per ownership tenure while the other requester waits (legal range 1..255).
- READ_LATENCY, 1, cycles from read acceptance to rdata_from_bridge being valid (legal range 1..4).

Ports:
- clk_from_cpu  in  1  system clock; all state updates on the rising edge.
- rst_from_cpu  in  1  synchronous, active-low reset.
- m0_req  in  1  requester 0 transfer request; held with addr/wen/wdata stable until m0_gnt is high.
- m0_addr  in  16  requester 0 byte address.
- m0_wen  in  1  requester 0 write (1) or read (0).
- m0_wdata  in  32  requester 0 write data.
- m0_gnt  out  1  transfer accepted this cycle (combinational).
- m0_rdata  out  32  read data, qualified by m0_rvalid.
- m0_rvalid  out  1  read data for requester 0 valid this cycle.
- m1_req, m1_addr, m1_wen, m1_wdata, m1_gnt, m1_rdata, m1_rvalid: same as the m0_* ports, for requester 1.
- addr_to_bridge  out  16  shared bus address.
- wen_to_bridge  out  1  shared bus write enable.
- wdata_to_bridge  out  32  shared bus write data.
- rdata_from_bridge  in  32  shared bus read data.
- owner  out  2  current owner: 0 = none, 1 = m0, 2 = m1 (debug and observability).

Behaviour:
- Clocking and reset: one clock domain; reset is synchronous and active-low.
- Reset values: state IDLE; rr_ptr = 0 (m0 favoured); beat_cnt = 0; read pipeline cleared; all rvalid = 0; owner = 0.
- Reset while a read is in flight drops the read; no rvalid is produced for it.
- State machine has three states: IDLE, OWN0, OWN1.
- IDLE:
  - no grants.
  - Exactly one requester → OWN of that requester.
  - Both requesting → OWN of the rr_ptr requester.
  - Neither → stay in IDLE.
  - Arbitration from IDLE costs one bubble cycle.
- OWNx:
  - mx_gnt = mx_req.
  - The bus carries mx_addr/mx_wen/mx_wdata.
  - wen_to_bridge = mx_wen & mx_req.
  - The other requester's gnt = 0.
- Bus outputs with no transfer: addr_to_bridge = 0, wen_to_bridge = 0, wdata_to_bridge = 0.
- beat_cnt:
  - increments on each accepted transfer in OWNx.
  - cleared on every state change.
- OWNx transitions, evaluated at the clock edge:
  - mx_req = 0 and other requesting → OWNother.
  - mx_req = 0 and other idle → IDLE.
  - Transfer accepted with beat_cnt+1 == MAX_BURST and other requesting → OWNother.
  - Burst limit reached but other not requesting → stay in OWNx and clear beat_cnt.
  - Otherwise stay in OWNx.
- Direct handover OWNx→OWNother has no bubble cycle.
- rr_ptr is set to the non-winning requester whenever ownership is taken.
- Read return:
  - Each accepted read pushes {valid, id} into a READ_LATENCY-deep shift register.
  - At the output stage: m{id}_rvalid = 1 for exactly one cycle.
  - Both m0_rdata and m1_rdata = rdata_from_bridge; they are meaningful only with rvalid.
  - Writes produce no rvalid.
  - Back-to-back reads are fully pipelined (throughput 1 per cycle).
- Ownership switches never drop or misroute in-flight read returns.
- MAX_BURST = 1 with both requesters continuously active: grants alternate every cycle, with no bubbles after the first.

Test Plan:
- Reset: hold rst_from_cpu = 0 for 3 cycles with m0_req = m1_req = 1 → no gnt, wen_to_bridge = 0, owner = 0, no rvalid; release → owner = 1 after 1 cycle.
- Single requester: m1 issues a read at 0xF000, then writes 0x0000_00FF to 0xF040.
  - One IDLE bubble, then gnt on consecutive cycles.
  - m1_rvalid 1 cycle after the read grant (READ_LATENCY = 1), with m1_rdata = rdata_from_bridge.
  - wen_to_bridge = 1 only in the write cycle.
- Contention with MAX_BURST = 8: both requesters held high.
  - m0 gets 8 grants, then m1 gets 8 grants with no bubble.
  - The pattern repeats; m0_gnt and m1_gnt are never both high.
- Early release: m0 owns and drops req after 3 beats with m1 requesting → owner = 2 on the next cycle; beat_cnt restarts at 0.
- Read tagging across handover: READ_LATENCY = 3, m0 reads at 0x4000 on the last beat of its burst, then m1 reads.
  - m0_rvalid fires 3 cycles after m0's grant.
  - m1_rvalid fires the following cycle.
  - No cross-delivery between requesters.
- Reset mid-read: assert reset in the cycle after a m0 read grant → m0_rvalid is never asserted; state returns to IDLE.
